uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//  Transmit stage of the UART, directly downstream of the 128x8 TX FIFO. Pops one byte per
//  frame through the FIFO's active-low read strobe and serialises it onto txd as
//  start / 7-or-8 data bits LSB-first / optional parity / stop. Runs on the system clock;
//  bit timing comes from a 16x baud enable.
// PARAMETERS
//  RD_LATENCY   2   clocks from the read_n-low edge to the edge at which fifo_data is valid
//  OVERSAMPLE   16  baud_en pulses per serial bit
// PORTS
//  clock        in   1  system clock; all logic is rising-edge
//  reset        in   1  asynchronous, active-high reset
//  baud_en      in   1  one-clock pulse at 16x the baud rate
//  fifo_empty   in   1  TX FIFO empty flag
//  fifo_data    in   8  TX FIFO registered output
//  fifo_read_n  out  1  TX FIFO read strobe, active low, one clock wide
//  bit8         in   1  1 = 8 data bits; 0 = 7 data bits (fifo_data[7] ignored)
//  parity_en    in   1  1 = append a parity bit
//  odd_n_even   in   1  1 = odd parity; 0 = even parity
//  txd          out  1  serial output, idles high
//  tx_busy      out  1  high from the fetch until the end of the stop bit
// BEHAVIOUR
//  Reset: state=IDLE, txd=1, fifo_read_n=1, tx_busy=0, tick counter=0, shift reg=0.
//    Reset mid-frame aborts the frame immediately; the popped byte is discarded.
//  States: IDLE, FETCH, WAIT_DATA, START, DATA, PARITY, STOP.
//  IDLE: if !fifo_empty -> FETCH. Otherwise hold txd=1.
//  FETCH (1 clk): drive fifo_read_n=0, tx_busy=1 -> WAIT_DATA.
//    Never drive fifo_read_n low while fifo_empty=1.
//  WAIT_DATA: wait RD_LATENCY-1 clocks, then on the next edge:
//    - load shift reg from fifo_data;
//    - latch bit8, parity_en and odd_n_even (changes mid-frame have no effect);
//    - clear the tick counter; -> START.
//  Bit timing: 4-bit tick counter increments on baud_en.
//    bit_done = baud_en && cnt==OVERSAMPLE-1; the counter wraps to 0 on it.
//    Each serial bit is therefore exactly 16 baud_en pulses.
//  START: txd=0. On bit_done -> DATA, bit index=0.
//  DATA: txd=shift[0]; shift right on each bit_done.
//    Leave after bit index 7 (bit8=1) or bit index 6 (bit8=0):
//    -> PARITY if parity_en, else -> STOP.
//  PARITY: txd = ^data_bits ^ odd_n_even, where data_bits are the 7 or 8 transmitted bits.
//    On bit_done -> STOP.
//  STOP: txd=1, one bit. On bit_done:
//    - if !fifo_empty -> FETCH (back-to-back, no IDLE gap beyond fetch latency);
//    - else -> IDLE, tx_busy=0.
//  txd is a register; it changes only on a state entry or on bit_done.
//  baud_en during FETCH or WAIT_DATA is ignored (counter cleared at load).
//  fifo_empty rising mid-frame has no effect; the frame always completes.
//  Exactly one read strobe is issued per transmitted frame.
// STRUCTURE
//  Shared package uart_pkg: state encoding localparams; OVERSAMPLE; parity function
//    par(data, bit8, odd) shared with the RX stage.
//  One sub-module, uart_baud_tick: 4-bit counter producing bit_done from baud_en,
//    with synchronous clear.
//  The top level holds the FSM, shift register, bit index and config latches.
// TESTING
//  1. FIFO holds 0x55; bit8=1, parity off; baud_en every 4 clk.
//     -> one read_n pulse; txd = 0,1,0,1,0,1,0,1,0,1; each bit 64 clk.
//  2. 0xA3, bit8=1, parity_en=1, odd_n_even=0 -> parity bit 0.
//     Repeat with odd_n_even=1 -> parity bit 1. Frame is 11 bits.
//  3. 0xFF, bit8=0, parity_en=1, even -> 7 data bits of 1, parity 1, stop.
//     Bit 7 is never driven.
//  4. Three bytes queued -> three read_n pulses. Each stop bit is followed within
//     RD_LATENCY+1 clocks by a start bit; tx_busy stays high throughout.
//  5. Assert reset in the middle of DATA -> txd=1 and tx_busy=0 asynchronously.
//     After release with FIFO empty: read_n stays high, txd stays 1.
//  6. Toggle bit8/parity inputs mid-frame -> frame format unchanged.
//     fifo_empty=1 throughout -> fifo_read_n never low.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Package : uart_pkg                                                          |
// | Brief   : Shared UART state encoding, oversample ratio and parity helper.   |
// | Rev     : 1.0                                                               |
// +-----------------------------------------------------------------------------+
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_WAIT_DATA = 3'd2;
  localparam logic [2:0] S_START     = 3'd3;
  localparam logic [2:0] S_DATA      = 3'd4;
  localparam logic [2:0] S_PARITY    = 3'd5;
  localparam logic [2:0] S_STOP      = 3'd6;

  // In 7-bit mode data[7] is excluded; odd=1 selects odd parity.
  function automatic logic par(input logic [7:0] data, input logic bit8, input logic odd);
    return (^data[6:0]) ^ (bit8 & data[7]) ^ odd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : uart_baud_tick                                                    |
// | Brief   : 4-bit oversample counter; flags the last baud_en of each bit.     |
// | Rev     : 1.0                                                               |
// +-----------------------------------------------------------------------------+
module uart_baud_tick #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic baud_en,
  output logic bit_done
);

  localparam logic [3:0] C_LAST = 4'(OVERSAMPLE - 1);

  logic [3:0] r_cnt;

  assign bit_done = baud_en && !clear && (r_cnt == C_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 4'd0;
    end else if (clear) begin
      r_cnt <= 4'd0;
    end else if (baud_en) begin
      r_cnt <= bit_done ? 4'd0 : r_cnt + 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : uart_tx_serializer                                                |
// | Brief   : Pops bytes from the TX FIFO and serialises start/data/parity/stop.|
// | Rev     : 1.0                                                               |
// +-----------------------------------------------------------------------------+
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int RD_LATENCY = 2,
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       baud_en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_read_n,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  output logic       txd,
  output logic       tx_busy
);

  localparam logic [3:0] C_WAIT_LAST = 4'(RD_LATENCY - 1);

  logic [2:0] r_state;
  logic [2:0] w_next_state;
  logic [3:0] r_wait_cnt;
  logic [7:0] r_shift;
  logic [2:0] r_bit_idx;
  logic       r_bit8;
  logic       r_par_en;
  logic       r_par;
  logic       r_txd;
  logic       w_txd_next;
  logic       w_bit_done;
  logic       w_tick_clear;
  logic       w_load;
  logic       w_last_bit;

  assign w_load       = (r_state == S_WAIT_DATA) && (r_wait_cnt == C_WAIT_LAST);
  assign w_last_bit   = (r_bit_idx == (r_bit8 ? 3'd7 : 3'd6));
  // Counter held clear outside the frame so every start bit gets a full 16 ticks.
  assign w_tick_clear = (r_state == S_IDLE) || (r_state == S_FETCH) || (r_state == S_WAIT_DATA);
  assign txd          = r_txd;

  uart_baud_tick #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_baud_tick (
    .clk      (clock),
    .rst      (reset),
    .clear    (w_tick_clear),
    .baud_en  (baud_en),
    .bit_done (w_bit_done)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      if (!fifo_empty) w_next_state = S_FETCH;
      S_FETCH:     w_next_state = fifo_empty ? S_IDLE : S_WAIT_DATA;
      S_WAIT_DATA: if (w_load) w_next_state = S_START;
      S_START:     if (w_bit_done) w_next_state = S_DATA;
      S_DATA:      if (w_bit_done && w_last_bit) w_next_state = r_par_en ? S_PARITY : S_STOP;
      S_PARITY:    if (w_bit_done) w_next_state = S_STOP;
      S_STOP:      if (w_bit_done) w_next_state = fifo_empty ? S_IDLE : S_FETCH;
      default:     w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_read_n = !((r_state == S_FETCH) && !fifo_empty);
    tx_busy     = (r_state != S_IDLE);
    w_txd_next  = 1'b1;
    case (w_next_state)
      S_START:  w_txd_next = 1'b0;
      S_DATA:   w_txd_next = ((r_state == S_DATA) && w_bit_done) ? r_shift[1] : r_shift[0];
      S_PARITY: w_txd_next = r_par;
      default:  w_txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_txd      <= 1'b1;
      r_wait_cnt <= 4'd0;
      r_shift    <= 8'd0;
      r_bit_idx  <= 3'd0;
      r_bit8     <= 1'b0;
      r_par_en   <= 1'b0;
      r_par      <= 1'b0;
    end else begin
      r_txd      <= w_txd_next;
      r_wait_cnt <= (r_state == S_WAIT_DATA) ? r_wait_cnt + 4'd1 : 4'd0;
      if (w_load) begin
        r_shift  <= fifo_data;
        r_bit8   <= bit8;
        r_par_en <= parity_en;
        r_par    <= par(fifo_data, bit8, odd_n_even);
      end
      if ((r_state == S_START) && w_bit_done) begin
        r_bit_idx <= 3'd0;
      end
      if ((r_state == S_DATA) && w_bit_done) begin
        r_shift   <= {1'b0, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : tb_uart_tx_serializer                                             |
// | Brief   : Directed vector bench for the UART transmit serializer.           |
// | Rev     : 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_uart_tx_serializer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       baud_en = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'd0;
  logic       fifo_read_n;
  logic       bit8 = 1'b1;
  logic       parity_en = 1'b0;
  logic       odd_n_even = 1'b0;
  logic       txd;
  logic       tx_busy;

  int checks = 0;
  int errors = 0;

  uart_tx_serializer #(.RD_LATENCY(2), .OVERSAMPLE(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .baud_en     (baud_en),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_read_n (fifo_read_n),
    .bit8        (bit8),
    .parity_en   (parity_en),
    .odd_n_even  (odd_n_even),
    .txd         (txd),
    .tx_busy     (tx_busy)
  );

  always #5 clock = ~clock;

  // baud_en one clock in every four
  int bcnt = 0;
  always @(posedge clock) begin
    bcnt    <= (bcnt == 3) ? 0 : bcnt + 1;
    baud_en <= (bcnt == 3);
  end

  // FIFO model: read sampled at edge E0, fifo_data valid for the DUT at E0+2
  logic [7:0] mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic [7:0] stage1 = 8'd0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  int rd_pulses = 0;
  int rd_while_empty = 0;

  always @(posedge clock) begin
    if (fifo_read_n === 1'b0) begin
      rd_pulses = rd_pulses + 1;
      if (fifo_empty) rd_while_empty = rd_while_empty + 1;
      if (rd_ptr != wr_ptr) begin
        stage1 <= mem[rd_ptr % 16];
        rd_ptr <= rd_ptr + 1;
      end
    end
    fifo_data <= stage1;
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 16] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_txd(input logic lvl, input int budget, output int n, output bit ok);
    n = 0;
    while (txd !== lvl && n < budget) begin
      @(negedge clock);
      n = n + 1;
    end
    ok = (n < budget);
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (tx_busy !== 1'b0 && n < 2000) begin
      @(negedge clock);
      n = n + 1;
    end
    ok = (n < 2000);
  endtask

  // Samples n bits mid-bit starting at the next start bit; optional mid-frame config toggling.
  task automatic capture(input int n, input bit toggle, output logic [10:0] cap, output bit ok);
    int t;
    cap = 11'd0;
    wait_txd(1'b0, 5000, t, ok);
    if (ok) begin
      repeat (32) @(negedge clock);
      for (int i = 0; i < n; i++) begin
        cap = {cap[9:0], txd};
        if (toggle) begin
          bit8       = ~bit8;
          parity_en  = ~parity_en;
          odd_n_even = ~odd_n_even;
        end
        if (i < n - 1) repeat (64) @(negedge clock);
      end
    end
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        b8;
    logic        pen;
    logic        odd;
    int          nbits;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [10:0] cap;
    bit ok;
    int n, p0, f0, t, busy_low;
    int falls [3];
    int nfalls;
    logic prev;

    // bit sequences in transmit order, start bit first
    vecs[0] = '{8'h55, 1'b1, 1'b0, 1'b0, 10, 11'b0_0101010101};
    vecs[1] = '{8'hA3, 1'b1, 1'b1, 1'b0, 11, 11'b01100010101};
    vecs[2] = '{8'hA3, 1'b1, 1'b1, 1'b1, 11, 11'b01100010111};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b0, 10, 11'b0_0111111111};
    vecs[4] = '{8'h00, 1'b0, 1'b1, 1'b1, 10, 11'b0_0000000011};
    vecs[5] = '{8'h80, 1'b0, 1'b0, 1'b0, 9,  11'b00_000000001};
    vecs[6] = '{8'h80, 1'b1, 1'b1, 1'b0, 11, 11'b00000000111};

    repeat (3) @(negedge clock);
    #1;
    check("reset_txd", 32'(txd), 32'd1);
    check("reset_busy", 32'(tx_busy), 32'd0);
    check("reset_read_n", 32'(fifo_read_n), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);

    // bit duration: data bit0 (1) and bit1 (0) of 0x55 last exactly 64 clocks
    bit8 = 1'b1; parity_en = 1'b0;
    push(8'h55);
    wait_txd(1'b0, 5000, t, ok);
    check("dur_start_seen", 32'(ok), 32'd1);
    wait_txd(1'b1, 200, t, ok);
    wait_txd(1'b0, 200, n, ok);
    check("dur_bit0", 32'(n), 32'd64);
    wait_txd(1'b1, 200, n, ok);
    check("dur_bit1", 32'(n), 32'd64);
    wait_idle(ok);
    check("dur_idle", 32'(ok), 32'd1);

    for (int v = 0; v < 7; v++) begin
      bit8 = vecs[v].b8; parity_en = vecs[v].pen; odd_n_even = vecs[v].odd;
      p0 = rd_pulses;
      push(vecs[v].data);
      capture(vecs[v].nbits, 1'b0, cap, ok);
      check($sformatf("vec%0d_frame", v), 32'(cap), 32'(vecs[v].exp));
      repeat (40) @(negedge clock);
      check($sformatf("vec%0d_end", v), {30'd0, tx_busy, txd}, 32'd1);
      check($sformatf("vec%0d_reads", v), 32'(rd_pulses - p0), 32'd1);
    end

    // three back-to-back 0xFF frames: only start bits fall
    bit8 = 1'b1; parity_en = 1'b0;
    p0 = rd_pulses;
    push(8'hFF); push(8'hFF); push(8'hFF);
    nfalls = 0; busy_low = 0; prev = 1'b1;
    for (int c = 0; c < 2100; c++) begin
      @(negedge clock);
      if (prev === 1'b1 && txd === 1'b0 && nfalls < 3) begin
        falls[nfalls] = c;
        nfalls = nfalls + 1;
      end
      if (nfalls > 0 && nfalls < 3 && tx_busy !== 1'b1) busy_low = busy_low + 1;
      prev = txd;
    end
    check("b2b_frames", 32'(nfalls), 32'd3);
    if (nfalls == 3) begin
      check("b2b_gap1", 32'((falls[1] - falls[0]) >= 640 && (falls[1] - falls[0]) <= 643), 32'd1);
      check("b2b_gap2", 32'((falls[2] - falls[1]) >= 640 && (falls[2] - falls[1]) <= 643), 32'd1);
    end
    check("b2b_busy_low", 32'(busy_low), 32'd0);
    check("b2b_reads", 32'(rd_pulses - p0), 32'd3);
    wait_idle(ok);
    check("b2b_idle", 32'(ok), 32'd1);

    // reset in the middle of DATA
    push(8'h00);
    wait_txd(1'b0, 5000, t, ok);
    repeat (32 + 64 * 3) @(negedge clock);
    check("rst_pre_txd", 32'(txd), 32'd0);
    reset = 1'b1;
    #1;
    check("rst_async_txd", 32'(txd), 32'd1);
    check("rst_async_busy", 32'(tx_busy), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    p0 = rd_pulses; n = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clock);
      if (txd !== 1'b1) n = n + 1;
    end
    check("rst_after_reads", 32'(rd_pulses - p0), 32'd0);
    check("rst_after_txd_low", 32'(n), 32'd0);

    // mid-frame config toggling must not alter the frame
    bit8 = 1'b1; parity_en = 1'b1; odd_n_even = 1'b0;
    push(8'hA3);
    capture(11, 1'b1, cap, ok);
    check("toggle_frame", 32'(cap), 32'(11'b01100010101));
    wait_idle(ok);
    check("toggle_idle", 32'(ok), 32'd1);

    check("read_while_empty", 32'(rd_while_empty), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
